conv_enc: RTL and testbench
===========================

CONV_ENC -- requirements
Module: conv_enc

Interface
REQ-001 Parameter TAIL_BITS, default 8, number of zero bits flushed through the encoder after each burst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset; one clock domain only.
REQ-004 i  input  1  data bit from the randomizer.
REQ-005 i_valid  input  1  i is valid this cycle.
REQ-006 i_last  input  1  qualifies i as the final data bit of the burst; sampled only on accept.
REQ-007 i_ready  output  1  encoder accepts i this cycle.
REQ-008 o  output  1  coded serial bit to the channel mapper, X then Y per input bit.
REQ-009 o_valid  output  1  o is valid.
REQ-010 o_ready  input  1  downstream accepts o this cycle.
REQ-011 o_last  output  1  marks the final coded bit of the burst.

Function
REQ-012 Code is rate 1/2, K=7, with G1=171 octal and G2=133 octal; s1..s6 is the shift register, s1 most recent.
REQ-013 Output bits: X = b^s1^s2^s3^s6 and Y = b^s2^s3^s5^s6, where b is the current input bit.
REQ-014 Input accept occurs when i_valid && i_ready; on accept, compute {X,Y}, load the output pair register, set pend=1 and phase=X, then shift b into s1.
REQ-015 Output handshake: o = X when phase=X, else Y.
  - o_valid = pend.
  - A transfer occurs when o_valid && o_ready.
  - A transfer in phase X sets phase=Y.
  - A transfer in phase Y clears pend, unless a new pair is loaded in the same cycle.
REQ-016 Flow control:
  - i_ready = (state==RUN) && (!pend || (phase==Y && o_ready)).
  - Back-to-back accepts every 2 cycles with o_ready held high give a continuous o stream with no bubble.
  - With o_ready held low, o, o_valid and phase hold stable.
REQ-017 States are RUN and TAIL.
  - RUN: accept an i_last=1 bit -> TAIL, and the tail counter loads TAIL_BITS.
  - TAIL: i_ready=0. Each time the pair register is free (same condition as i_ready, state ignored), internally encode b=0 and decrement the counter.
  - TAIL: when the counter reaches 0 and the final pair has fully transferred -> RUN.
REQ-018 o_last=1 only during the Y bit of the last tail pair; burst output length = 2*(N+TAIL_BITS) for N data bits.
REQ-019 After the tail, the shift register is all zero; each burst starts from the zero state.
REQ-020 If i_valid is low, nothing is accepted and the state is unchanged; gaps between input bits shall not alter the code sequence.
REQ-021 Latency: o_valid rises the cycle after accept; X appears 1 cycle after accept and Y at least 2 cycles after accept.
REQ-022 i_last accepted with TAIL_BITS=0 goes straight to RUN after the final pair, and o_last marks that pair's Y bit.

Reset
REQ-023 reset forces state=RUN, s1..s6=0, pend=0, phase=X, tail counter=0, o=0, o_valid=0, o_last=0 and i_ready=1 on the following cycle.
REQ-024 reset mid-burst, in RUN or TAIL, discards pending output without emitting o_last, and the next accepted bit encodes from the zero state.

Verification
REQ-025 After reset, accept 1 then 0 with o_ready=1 -> o = 1,1,1,0.
REQ-026 After reset, accept 1 then 1 -> o = 1,1,0,1.
REQ-027 Single-bit burst i=1, i_last=1, TAIL_BITS=8, o_ready=1.
  - Response: 18 bits 11 10 11 11 00 01 11 00 00.
  - o_last is set on bit 18, and i_ready=0 from accept through bit 18.
REQ-028 o_ready toggled 1-in-3 over a 32-bit random burst -> the output sequence matches a reference model bit-exactly, with no drop, duplicate or change while o_valid && !o_ready.
REQ-029 Assert reset during TAIL after 5 tail bits -> o_valid=0 next cycle, then a new burst starting with 1 gives o = 1,1.
REQ-030 Two bursts back to back, with the second i_valid held high during TAIL -> the second burst is not accepted until RUN, and its first pair equals the zero-state encoding.

Source files
------------

// File: rtl/conv_enc.sv
// Rate 1/2, K=7 convolutional encoder (G1=171, G2=133 octal).
// Each accepted bit is emitted as an X/Y pair on a serial ready/valid output.
// After the last bit of a burst, TAIL_BITS zero bits are flushed through the
// encoder so that every burst ends, and the next one starts, from the zero state.
module conv_enc #(
  parameter int TAIL_BITS = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i,
  input  logic i_valid,
  input  logic i_last,
  output logic i_ready,
  output logic o,
  output logic o_valid,
  input  logic o_ready,
  output logic o_last
);

  // The counter must hold TAIL_BITS and still be at least one bit wide when TAIL_BITS is 0.
  localparam int CW = $clog2(TAIL_BITS + 2);

  typedef enum logic {RUN, TAIL} state_t;

  state_t          state_q, state_d;
  logic [5:0]      shift_q, shift_d;
  logic [1:0]      pair_q, pair_d;
  logic            pend_q, pend_d;
  logic            phase_q, phase_d;
  logic            last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic free;
  logic xfer;
  logic accept;
  logic tail_load;
  logic load;
  logic b;
  logic x_bit;
  logic y_bit;

  // Handshakes, encoder taps and next-state for the shift register, pair register and burst FSM.
  always_comb begin
    free      = !pend_q || (phase_q && o_ready);
    xfer      = pend_q && o_ready;
    accept    = i_valid && (state_q == RUN) && free;
    tail_load = (state_q == TAIL) && free && (cnt_q != '0);
    load      = accept || tail_load;
    b         = accept ? i : 1'b0;
    x_bit     = b ^ shift_q[0] ^ shift_q[1] ^ shift_q[2] ^ shift_q[5];
    y_bit     = b ^ shift_q[1] ^ shift_q[2] ^ shift_q[4] ^ shift_q[5];

    state_d = state_q;
    shift_d = shift_q;
    pair_d  = pair_q;
    pend_d  = pend_q;
    phase_d = phase_q;
    last_d  = last_q;
    cnt_d   = cnt_q;

    if (xfer) begin
      if (!phase_q) begin
        phase_d = 1'b1;
      end else begin
        pend_d = 1'b0;
      end
    end

    if (load) begin
      pair_d  = {x_bit, y_bit};
      pend_d  = 1'b1;
      phase_d = 1'b0;
      shift_d = {shift_q[4:0], b};
      if (accept) begin
        last_d = i_last && (TAIL_BITS == 0);
      end else begin
        last_d = (cnt_q == CW'(1));
      end
    end

    if (accept && i_last) begin
      state_d = TAIL;
      cnt_d   = CW'(TAIL_BITS);
    end

    if (tail_load) begin
      cnt_d = cnt_q - CW'(1);
    end

    if ((state_q == TAIL) && (cnt_q == '0) && free) begin
      state_d = RUN;
    end
  end

  // Output mux: X goes out first, then Y; o_last flags the Y bit of the burst's final pair.
  always_comb begin
    i_ready = (state_q == RUN) && free;
    o       = phase_q ? pair_q[0] : pair_q[1];
    o_valid = pend_q;
    o_last  = pend_q && phase_q && last_q;
  end

  // State registers with synchronous reset back to an idle, zero-state encoder.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      shift_q <= '0;
      pair_q  <= '0;
      pend_q  <= 1'b0;
      phase_q <= 1'b0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      pair_q  <= pair_d;
      pend_q  <= pend_d;
      phase_q <= phase_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_conv_enc.sv
// Self-checking bench for conv_enc: fixed vectors from a table plus hand-written
// sequences, with every output bit compared against a queue of expected bits.
module tb_conv_enc;

  localparam int TB_TAIL = 8;

  logic clk;
  logic reset;
  logic i;
  logic i_valid;
  logic i_last;
  logic i_ready;
  logic o;
  logic o_valid;
  logic o_ready;
  logic o_last;

  int checks;
  int failures;
  int rdy_mode;

  typedef struct packed {
    logic bit_v;
    logic last;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    int          n;
    logic [31:0] data;
    logic        last;
    int          explen;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[3];

  logic [5:0] mstate;
  logic       stall_v;
  logic       stall_o;

  conv_enc #(.TAIL_BITS(TB_TAIL)) dut (
    .clk     (clk),
    .reset   (reset),
    .i       (i),
    .i_valid (i_valid),
    .i_last  (i_last),
    .i_ready (i_ready),
    .o       (o),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_last  (o_last)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Downstream ready pattern: always ready, ready one cycle in three, or stalled.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       o_ready = 1'b1;
      1:       o_ready = ($urandom_range(0, 2) == 0);
      default: o_ready = 1'b0;
    endcase
  end

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  // Bit-level reference encoder: pushes the X/Y pair for b and advances its shift register.
  task automatic pushModel(input logic b, input logic last);
    logic x_e;
    logic y_e;
    x_e = b ^ mstate[0] ^ mstate[1] ^ mstate[2] ^ mstate[5];
    y_e = b ^ mstate[1] ^ mstate[2] ^ mstate[4] ^ mstate[5];
    sb.push_back({x_e, 1'b0});
    sb.push_back({y_e, last});
    mstate = {mstate[4:0], b};
  endtask

  task automatic pushTail();
    for (int k = 0; k < TB_TAIL; k++) pushModel(1'b0, k == TB_TAIL - 1);
  endtask

  task automatic doReset();
    reset = 1'b1;
    i_valid = 1'b0;
    i_last = 1'b0;
    sb.delete();
    mstate = '0;
    @(posedge clk);
    #1;
    checkOutput("reset_o_valid", o_valid, 1'b0);
    checkOutput("reset_i_ready", i_ready, 1'b1);
    checkOutput("reset_o_last", o_last, 1'b0);
    checkOutput("reset_o", o, 1'b0);
    reset = 1'b0;
  endtask

  // Holds i_valid until the encoder accepts the bit; returns at posedge+1 after the accepting edge.
  task automatic applyStimulus(input logic b, input logic last);
    logic acc;
    acc = 1'b0;
    i = b;
    i_last = last;
    i_valid = 1'b1;
    for (int c = 0; c < 2000 && !acc; c++) begin
      @(negedge clk);
      acc = i_ready;
      @(posedge clk);
      #1;
    end
    i_valid = 1'b0;
    i_last = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout: got no accept expected accept at %0t", $time);
    end
  endtask

  task automatic waitDrain();
    for (int c = 0; c < 3000 && sb.size() != 0; c++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("drain_empty", sb.size() == 0, 1'b1);
  endtask

  // Output monitor: pops the scoreboard on every transfer and checks that a stalled bit holds.
  always @(negedge clk) begin
    if (reset) begin
      stall_v = 1'b0;
    end else begin
      if (stall_v) begin
        checkOutput("stall_valid", o_valid, 1'b1);
        checkOutput("stall_hold", o, stall_o);
      end
      if (o_valid && o_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_out: got bit %b expected no output at %0t", o, $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("o_bit", o, e.bit_v);
          checkOutput("o_last", o_last, e.last);
        end
        stall_v = 1'b0;
      end else if (o_valid) begin
        stall_v = 1'b1;
        stall_o = o;
      end else begin
        stall_v = 1'b0;
        checkOutput("idle_o_last", o_last, 1'b0);
      end
    end
  end

  // Main test sequence.
  initial begin
    checks = 0;
    failures = 0;
    rdy_mode = 0;
    o_ready = 1'b1;
    reset = 1'b1;
    i = 1'b0;
    i_valid = 1'b0;
    i_last = 1'b0;
    mstate = '0;
    stall_v = 1'b0;
    stall_o = 1'b0;

    vecs[0] = '{n: 2, data: 32'b01, last: 1'b0, explen: 4,  exp: 64'b1110};
    vecs[1] = '{n: 2, data: 32'b11, last: 1'b0, explen: 4,  exp: 64'b1101};
    vecs[2] = '{n: 1, data: 32'b1,  last: 1'b1, explen: 18, exp: 64'b11_10_11_11_00_01_11_00_00};

    repeat (2) @(posedge clk);
    #1;

    for (int v = 0; v < 3; v++) begin
      doReset();
      rdy_mode = 0;
      for (int k = 0; k < vecs[v].explen; k++) begin
        sb.push_back({vecs[v].exp[vecs[v].explen - 1 - k], vecs[v].last && (k == vecs[v].explen - 1)});
      end
      for (int k = 0; k < vecs[v].n; k++) begin
        applyStimulus(vecs[v].data[k], vecs[v].last && (k == vecs[v].n - 1));
        if (k == 0) begin
          checkOutput("latency_o_valid", o_valid, 1'b1);
          checkOutput("latency_x", o, vecs[v].exp[vecs[v].explen - 1]);
        end
      end
      if (vecs[v].last) begin
        for (int c = 0; c < vecs[v].explen; c++) begin
          checkOutput("tail_i_ready_low", i_ready, 1'b0);
          @(posedge clk);
          #1;
        end
        checkOutput("tail_i_ready_back", i_ready, 1'b1);
      end
      waitDrain();
    end

    // Random 32-bit burst with downstream ready one cycle in three.
    doReset();
    rdy_mode = 1;
    for (int k = 0; k < 32; k++) begin
      logic b;
      b = 1'($urandom_range(0, 1));
      applyStimulus(b, k == 31);
      pushModel(b, 1'b0);
    end
    pushTail();
    waitDrain();
    rdy_mode = 0;

    // Reset during the tail after five tail pairs, then a fresh burst from the zero state.
    doReset();
    applyStimulus(1'b1, 1'b1);
    pushModel(1'b1, 1'b0);
    pushTail();
    repeat (12) begin
      @(posedge clk);
      #1;
    end
    doReset();
    checkOutput("midreset_o_valid", o_valid, 1'b0);
    applyStimulus(1'b1, 1'b0);
    sb.push_back({1'b1, 1'b0});
    sb.push_back({1'b1, 1'b0});
    waitDrain();

    // Back-to-back bursts: the second bit waits out the tail of the first.
    doReset();
    applyStimulus(1'b1, 1'b0);
    pushModel(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    pushModel(1'b0, 1'b0);
    pushTail();
    applyStimulus(1'b1, 1'b0);
    checkOutput("second_after_tail", sb.size() == 0, 1'b1);
    sb.push_back({1'b1, 1'b0});
    sb.push_back({1'b1, 1'b0});
    waitDrain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
